fetch_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage_if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I fetch stage and its pipeline registers.
package fetch_stage_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 -- placed in an empty pipeline slot.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Contents of a stage register: instruction, its PC, and a live flag.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Force a fetch target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_rdata,
        output imem_resp
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Load/flush/hold pipeline register for {instr, pc, valid}.
// Priority: rst > flush > load > bubble > hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter logic [31:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // Stage register update; a flush kills the slot and plants a NOP, a bubble only clears valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            q <= '{instr: FLUSH_INSTR, pc: RESET_PC, valid: 1'b0};
        end else if (flush) begin
            q.instr <= FLUSH_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (bubble) begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps one read outstanding,
// parks a response in a skid buffer while decode stalls, and drains a stale request on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic [31:0]          instr_id,
    output logic [31:0]          pc_id,
    output logic                 valid_id
);
    import fetch_stage_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic         read_q;

    logic [31:0]  target;
    logic         accept;

    logic         ifid_load;
    logic         ifid_flush;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // The request is never shown to memory while the core is held in reset.
    assign imem.imem_read    = read_q & ~rst;
    // In DISCARD pc still holds the stale address, so the request stays stable.
    assign imem.imem_address = pc;

    // A response counts only against a visible request.
    assign accept = imem.imem_read & imem.imem_resp;
    assign target = word_align(redirect_pc_i);

    // IF/ID register control derived from state, handshake and redirect.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{instr: imem.imem_rdata, pc: pc, valid: 1'b1};
        if (redirect_i) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (accept && !stall_i) begin
                        ifid_load = 1'b1;
                    end else if (!accept && !stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end
                BUFFERED: begin
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                        ifid_d    = '{instr: skid_instr, pc: skid_pc, valid: 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM, PC, pending redirect target and skid buffer, with registered read request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            next_pc    <= RESET_PC;
            // NOTE: the skid data is cleared on reset only so it starts empty and X-free; BUFFERED marks it full.
            skid_instr <= NOP_INSTR;
            skid_pc    <= RESET_PC;
            read_q     <= 1'b1;
        end else if (redirect_i) begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc <= target;
                    end else begin
                        // The in-flight request cannot be retracted: wait it out.
                        next_pc <= target;
                        state   <= DISCARD;
                    end
                end
                BUFFERED: begin
                    skid_instr <= NOP_INSTR;
                    skid_pc    <= RESET_PC;
                    pc         <= target;
                    state      <= FETCH;
                    read_q     <= 1'b1;
                end
                DISCARD: begin
                    next_pc <= target;
                end
                default: begin
                    state  <= FETCH;
                    read_q <= 1'b1;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        if (stall_i) begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= pc;
                            state      <= BUFFERED;
                            read_q     <= 1'b0;
                        end else begin
                            pc <= next_word(pc);
                        end
                    end
                end
                BUFFERED: begin
                    if (!stall_i) begin
                        pc     <= next_word(skid_pc);
                        state  <= FETCH;
                        read_q <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (accept) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state  <= FETCH;
                    read_q <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .RESET_PC    (RESET_PC),
        .FLUSH_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .flush  (ifid_flush),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign instr_id = ifid_q.instr;
    assign pc_id    = ifid_q.pc;
    assign valid_id = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } held_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        valid_id;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .valid_id      (valid_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls: fixed latency (>=0) or random 0..2 (<0); spurious resp when idle.
    int lat_mode  = 0;
    bit spur      = 1'b0;
    bit mem_busy  = 1'b0;
    int remaining = 0;

    // Reference model: fetch address, stale-request bookkeeping, parked response, IF/ID view.
    logic [31:0] m_addr;
    logic [31:0] m_target;
    bit          m_stale;
    held_t       held_q[$];
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory answers a visible request after its latency; may emit junk resp when idle.
    task automatic mem_drive();
        if (rst) begin
            mem_busy = 1'b0;
            bus.imem_resp  = 1'b0;
            bus.imem_rdata = 32'h0;
        end else if (bus.imem_read) begin
            if (!mem_busy) begin
                mem_busy  = 1'b1;
                remaining = (lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode;
            end
            if (remaining == 0) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_address);
                mem_busy       = 1'b0;
            end else begin
                remaining--;
                bus.imem_resp  = 1'b0;
                bus.imem_rdata = $urandom;
            end
        end else begin
            mem_busy       = 1'b0;
            bus.imem_resp  = spur && ($urandom_range(3, 0) == 0);
            bus.imem_rdata = $urandom;
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sees at this edge.
    task automatic model_step();
        bit          acc;
        logic [31:0] tgt;
        held_t       h;
        if (rst) begin
            m_addr  = RESET_PC;
            m_stale = 1'b0;
            held_q.delete();
            e_valid = 1'b0;
            e_instr = NOP;
            e_pc    = RESET_PC;
            return;
        end
        acc = (held_q.size() == 0) && bus.imem_resp;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (redirect) begin
            e_valid = 1'b0;
            e_instr = NOP;
            if (m_stale) begin
                m_target = tgt;
            end else if (held_q.size() != 0 || acc) begin
                held_q.delete();
                m_addr = tgt;
            end else begin
                m_stale  = 1'b1;
                m_target = tgt;
            end
        end else if (m_stale) begin
            if (acc) begin
                m_stale = 1'b0;
                m_addr  = m_target;
            end
        end else if (held_q.size() != 0) begin
            if (!stall) begin
                h       = held_q.pop_front();
                e_valid = 1'b1;
                e_instr = h.instr;
                e_pc    = h.pc;
                m_addr  = h.pc + 32'd4;
            end
        end else if (acc) begin
            if (stall) begin
                held_q.push_back('{instr: bus.imem_rdata, pc: m_addr});
            end else begin
                e_valid = 1'b1;
                e_instr = bus.imem_rdata;
                e_pc    = m_addr;
                m_addr  = m_addr + 32'd4;
            end
        end else if (!stall) begin
            e_valid = 1'b0;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        logic exp_read;
        exp_read = !rst && (held_q.size() == 0);
        check("valid_id", {31'h0, valid_id}, {31'h0, e_valid});
        check("instr_id", instr_id, e_instr);
        check("pc_id", pc_id, e_pc);
        check("imem_read", {31'h0, bus.imem_read}, {31'h0, exp_read});
        if (exp_read) check("imem_address", bus.imem_address, m_addr);
    endtask

    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        mem_drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.imem_resp = 1'b0; bus.imem_rdata = 32'h0;

        // Reset, memory answers in the request cycle.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_valid", {31'h0, valid_id}, 32'h0);
        check("rst_instr", instr_id, 32'h0000_0013);
        check("rst_pc_id", pc_id, 32'h4000_0000);
        check("rst_read", {31'h0, bus.imem_read}, 32'h0);
        lat_mode = 0;
        cycle(0, 0, 0, 0);
        check("t1_pc0", pc_id, 32'h4000_0000);
        check("t1_valid0", {31'h0, valid_id}, 32'h1);
        cycle(0, 0, 0, 0);
        check("t1_pc1", pc_id, 32'h4000_0004);
        check("t1_instr1", instr_id, 32'h4000_0004 ^ 32'h1357_9BDF);

        // Stall while the response for 0x4000_0008 arrives, hold for three cycles.
        cycle(0, 1, 0, 0);
        check("t2_frozen", pc_id, 32'h4000_0004);
        check("t2_read_off", {31'h0, bus.imem_read}, 32'h0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("t2_still_frozen", pc_id, 32'h4000_0004);
        cycle(0, 0, 0, 0);
        check("t2_release_pc", pc_id, 32'h4000_0008);
        check("t2_next_addr", bus.imem_address, 32'h4000_000C);

        // Redirect while a request is pending; response comes two cycles later.
        lat_mode = 2;
        cycle(0, 0, 1, 32'h4000_0100);
        check("t3_addr_held", bus.imem_address, 32'h4000_000C);
        check("t3_valid0", {31'h0, valid_id}, 32'h0);
        cycle(0, 0, 0, 0);
        check("t3_addr_held2", bus.imem_address, 32'h4000_000C);
        cycle(0, 0, 0, 0);
        check("t3_target_addr", bus.imem_address, 32'h4000_0100);
        check("t3_valid_still0", {31'h0, valid_id}, 32'h0);
        lat_mode = 0;
        cycle(0, 0, 0, 0);
        check("t3_target_pc", pc_id, 32'h4000_0100);

        // Redirect with stall asserted while a response is parked.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h4000_0202);
        check("t4_valid0", {31'h0, valid_id}, 32'h0);
        check("t4_nop", instr_id, 32'h0000_0013);
        check("t4_addr", bus.imem_address, 32'h4000_0200);
        cycle(0, 0, 0, 0);
        check("t4_pc", pc_id, 32'h4000_0200);

        // Redirect to the top of the address space; the following fetch wraps.
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        check("t5_addr", bus.imem_address, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        check("t5_wrap_addr", bus.imem_address, 32'h0000_0000);
        check("t5_pc", pc_id, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        check("t5_wrap_pc", pc_id, 32'h0000_0000);

        // Reset while draining a stale request.
        lat_mode = 2;
        cycle(0, 0, 1, 32'h4000_0300);
        cycle(1, 0, 0, 0);
        check("t6_valid", {31'h0, valid_id}, 32'h0);
        check("t6_instr", instr_id, 32'h0000_0013);
        check("t6_pc", pc_id, 32'h4000_0000);
        lat_mode = 0;
        cycle(0, 0, 0, 0);
        check("t6_refetch", pc_id, 32'h4000_0000);

        // Randomized traffic: variable latency, spurious responses, stalls, redirects, resets.
        lat_mode = -1;
        spur     = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic        r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(99, 0) == 0);
            s   = ($urandom_range(99, 0) < 30);
            rd  = ($urandom_range(99, 0) < 8);
            rpc = ($urandom_range(1, 0) == 0) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)));
            cycle(r, s, rd, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
